// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-atomic arbiter for the write port of a width-converting FIFO.
// Each grant moves exactly BURST_LEN beats so a packed FIFO word never mixes sources.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 4,
  parameter int BURST_LEN = 4,
  parameter int STALL_MAX = 15,
  parameter int ID_W      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fifo_wen,
  output logic [DATA_W-1:0]         fifo_wdata,
  input  logic                      fifo_wfull,
  input  logic                      fifo_prog_full,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic                      err_stall
);

  localparam int CNT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int STALL_W = $clog2(STALL_MAX + 1);
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [STALL_W-1:0] STALL_TOP = STALL_W'(STALL_MAX);
  localparam logic [STALL_W-1:0] STALL_PRE = STALL_W'(STALL_MAX - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state;
  logic [ID_W-1:0]     last_id;
  logic [CNT_W-1:0]    beat_cnt;
  logic [STALL_W-1:0]  stall_cnt;
  logic [DATA_W-1:0]   wdata_hold;

  logic [ID_W-1:0]     pick_id;
  logic                pick_found;
  logic                beat_valid;
  logic [DATA_W-1:0]   beat_data;
  logic                handshake;

  // Walk offsets from farthest to nearest so the nearest valid index after last_id wins.
  always_comb begin
    int idx;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last_id) + off) % NUM_REQ;
      if (req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  assign beat_valid = req_valid[grant_id];
  assign beat_data  = req_data[int'(grant_id)*DATA_W +: DATA_W];
  assign fifo_wen   = (state == XFER) && beat_valid && !fifo_wfull;
  assign handshake  = fifo_wen;
  assign fifo_wdata = fifo_wen ? beat_data : wdata_hold;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (state == XFER) && (grant_id == ID_W'(gi)) && !fifo_wfull;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_id     <= ID_W'(NUM_REQ - 1);
      beat_cnt    <= '0;
      stall_cnt   <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      err_stall   <= 1'b0;
      wdata_hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found && !fifo_prog_full) begin
            grant_id    <= pick_id;
            grant_valid <= 1'b1;
            beat_cnt    <= '0;
            stall_cnt   <= '0;
            state       <= XFER;
          end
        end
        XFER: begin
          if (handshake) begin
            wdata_hold <= beat_data;
            stall_cnt  <= '0;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt    <= '0;
              last_id     <= grant_id;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (!beat_valid) begin
            // Requester starvation only; back-pressure from a full FIFO is not a stall.
            if (stall_cnt != STALL_TOP) stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt >= STALL_PRE) err_stall <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Table-driven directed test of fifo_wr_arbiter: each row drives inputs for one cycle
// and checks the outputs seen in that cycle before the next rising edge.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_wen;
  logic [3:0]  fifo_wdata;
  logic        fifo_wfull;
  logic        fifo_prog_full;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        err_stall;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_wr_arbiter #(
    .NUM_REQ(4), .DATA_W(4), .BURST_LEN(4), .STALL_MAX(15), .ID_W(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata),
    .fifo_wfull(fifo_wfull), .fifo_prog_full(fifo_prog_full),
    .grant_valid(grant_valid), .grant_id(grant_id), .err_stall(err_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [15:0] data;
    logic        wfull;
    logic        pfull;
    logic        chk;
    logic        gv;
    logic [1:0]  gid;
    logic        wen;
    logic [3:0]  wdata;
    logic [3:0]  ready;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [15:0] d,
                     input logic wf, input logic pf, input logic c,
                     input logic gv, input logic [1:0] gid, input logic wen,
                     input logic [3:0] wd, input logic [3:0] rdy, input logic err);
    vec_t t;
    t.rst = r; t.valid = v; t.data = d; t.wfull = wf; t.pfull = pf; t.chk = c;
    t.gv = gv; t.gid = gid; t.wen = wen; t.wdata = wd; t.ready = rdy; t.err = err;
    vecs.push_back(t);
  endtask

  task automatic cmp(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_wfull = 1'b0; fifo_prog_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    cmp("reset_grant_valid", -1, 32'(grant_valid), 32'd0);
    cmp("reset_grant_id",    -1, 32'(grant_id),    32'd0);
    cmp("reset_wen",         -1, 32'(fifo_wen),    32'd0);
    cmp("reset_wdata",       -1, 32'(fifo_wdata),  32'd0);
    cmp("reset_ready",       -1, 32'(req_ready),   32'd0);
    cmp("reset_err",         -1, 32'(err_stall),   32'd0);

    // Single requester 2 streaming 1..4
    add(0, 4'b0100, 16'h0100, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0);
    for (int b = 1; b <= 4; b++)
      add(0, 4'b0100, {4'h0, 4'(b), 8'h00}, 0, 0, 1, 1, 2'd2, 1, 4'(b), 4'b0100, 0);
    add(0, 4'b0000, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0);

    // All four continuously: order 0,1,2,3,0 with a one-cycle bubble between bursts
    add(1, 4'b0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'b1111, 16'hDCBA, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0);
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++)
        add(0, 4'b1111, 16'hDCBA, 0, 0, 1, 1, 2'(b % 4), 1, 4'(10 + b % 4),
            4'(1 << (b % 4)), 0);
      add(0, 4'b1111, 16'hDCBA, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0);
    end

    // fifo_wfull held for 3 cycles at beat 2 of requester 1
    add(1, 4'b0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0010, 16'h0010, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0);
    add(0, 4'b0010, 16'h0010, 0, 0, 1, 1, 2'd1, 1, 4'd1, 4'b0010, 0);
    for (int k = 0; k < 3; k++)
      add(0, 4'b0010, 16'h0020, 1, 0, 1, 1, 2'd1, 0, 0, 4'b0000, 0);
    for (int b = 2; b <= 4; b++)
      add(0, 4'b0010, {8'h00, 4'(b), 4'h0}, 0, 0, 1, 1, 2'd1, 1, 4'(b), 4'b0010, 0);
    add(0, 4'b0000, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0);

    // prog_full blocks grants in IDLE but not an ongoing burst
    add(1, 4'b0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      add(0, 4'b1111, 16'hDCBA, 0, 1, 1, 0, 0, 0, 0, 4'b0000, 0);
    add(0, 4'b1111, 16'hDCBA, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0);
    for (int k = 0; k < 4; k++)
      add(0, 4'b1111, 16'hDCBA, 0, 1, 1, 1, 2'd0, 1, 4'hA, 4'b0001, 0);
    add(0, 4'b1111, 16'hDCBA, 0, 1, 1, 0, 0, 0, 0, 4'b0000, 0);
    add(0, 4'b1111, 16'hDCBA, 0, 1, 1, 0, 0, 0, 0, 4'b0000, 0);

    // Requester 3 drops valid for 15 cycles after beat 1
    add(1, 4'b0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'b1000, 16'h1000, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0);
    add(0, 4'b1000, 16'h1000, 0, 0, 1, 1, 2'd3, 1, 4'd1, 4'b1000, 0);
    for (int k = 0; k < 15; k++)
      add(0, 4'b0000, 16'h1000, 0, 0, 1, 1, 2'd3, 0, 0, 4'b1000, 0);
    for (int b = 2; b <= 4; b++)
      add(0, 4'b1000, {4'(b), 12'h000}, 0, 0, 1, 1, 2'd3, 1, 4'(b), 4'b1000, 1);
    add(0, 4'b0000, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 1);
    add(0, 4'b0000, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 1);
    add(1, 4'b0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0);

    // Reset during beat 2 of requester 2, after requester 1 has completed a burst
    add(1, 4'b0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0010, 16'h0050, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0);
    for (int k = 0; k < 4; k++)
      add(0, 4'b0010, 16'h0050, 0, 0, 1, 1, 2'd1, 1, 4'd5, 4'b0010, 0);
    add(0, 4'b0100, 16'h0600, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0);
    add(0, 4'b0100, 16'h0600, 0, 0, 1, 1, 2'd2, 1, 4'd6, 4'b0100, 0);
    add(1, 4'b0100, 16'h0600, 0, 0, 1, 1, 2'd2, 1, 4'd6, 4'b0100, 0);
    add(0, 4'b0111, 16'h0657, 0, 0, 1, 0, 0, 0, 0, 4'b0000, 0);
    add(0, 4'b0111, 16'h0657, 0, 0, 1, 1, 2'd0, 1, 4'd7, 4'b0001, 0);

    foreach (vecs[i]) begin
      rst            = vecs[i].rst;
      req_valid      = vecs[i].valid;
      req_data       = vecs[i].data;
      fifo_wfull     = vecs[i].wfull;
      fifo_prog_full = vecs[i].pfull;
      #1;
      $display("row %0d rst=%b valid=%b wfull=%b pfull=%b -> gv=%b gid=%0d wen=%b wdata=%h ready=%b err=%b",
               i, rst, req_valid, fifo_wfull, fifo_prog_full,
               grant_valid, grant_id, fifo_wen, fifo_wdata, req_ready, err_stall);
      if (vecs[i].chk) begin
        cmp("grant_valid", i, 32'(grant_valid), 32'(vecs[i].gv));
        if (vecs[i].gv) cmp("grant_id", i, 32'(grant_id), 32'(vecs[i].gid));
        cmp("fifo_wen", i, 32'(fifo_wen), 32'(vecs[i].wen));
        if (vecs[i].wen) cmp("fifo_wdata", i, 32'(fifo_wdata), 32'(vecs[i].wdata));
        cmp("req_ready", i, 32'(req_ready), 32'(vecs[i].ready));
        cmp("err_stall", i, 32'(err_stall), 32'(vecs[i].err));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
